// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared widths and types for the parallel_to_serial block
//
// Purpose : default word width, bit-counter width and the word type used by
//           the parallel-to-serial shifter and its optional bit counter.
// Ports   : none (package).
package p2s_pkg;

  localparam int P2S_WIDTH_DEFAULT = 32;
  localparam int P2S_CNT_W         = $clog2(P2S_WIDTH_DEFAULT + 1);

  typedef logic [P2S_WIDTH_DEFAULT-1:0] p2s_word_t;

endpackage

// File: rtl/p2s_bit_counter.sv
// rtl/p2s_bit_counter.sv - saturating shift counter for the serialiser
//
// Purpose : counts shifts from 0 up to WIDTH and then holds; cleared by load.
// Ports   :
//   clk      in   serial clock
//   reset_n  in   asynchronous active-low reset
//   i_clear  in   clear to 0 (load has priority over shifting)
//   i_inc    in   one shift happened this edge
//   o_cnt    out  shifts performed since the last load, 0..WIDTH
//   o_done   out  high when o_cnt == WIDTH
module p2s_bit_counter
  import p2s_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = w_full;

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - parallel-load MSB-first serialiser
//
// Purpose : captures a parallel word while load is high and shifts it out
//           MSB first, one bit per clk while en is high. ser is forced to 0
//           whenever en is low.
// Build   : define P2S_BIT_COUNT_EN to add the bit_cnt / done outputs.
// Ports   :
//   clk      in   serial clock, all state changes on its rising edge
//   reset_n  in   asynchronous active-low reset
//   load     in   level; reload data_in every edge while high (beats en)
//   en       in   level; output enable and shift enable
//   data_in  in   WIDTH-bit parallel word
//   ser      out  serial data, MSB first, 0 while en is low
//   bit_cnt  out  (P2S_BIT_COUNT_EN) shifts since last load, saturates at WIDTH
//   done     out  (P2S_BIT_COUNT_EN) high when bit_cnt == WIDTH
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int WIDTH = P2S_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic                       en,
  input  logic [WIDTH-1:0]           data_in,
`ifdef P2S_BIT_COUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       done,
`endif
  output logic                       ser
);

  logic [WIDTH-1:0] r_shreg;
  logic             w_shift;

  assign w_shift = en && !load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
    end else if (load) begin
      r_shreg <= data_in;
    end else if (en) begin
      // Zero fill: once every bit has gone out the line stays low.
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  // Combinational gate so the MSB is visible as soon as en rises.
  assign ser = en & r_shreg[WIDTH-1];

`ifdef P2S_BIT_COUNT_EN
  p2s_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W ($clog2(WIDTH + 1))
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (load),
    .i_inc   (w_shift),
    .o_cnt   (bit_cnt),
    .o_done  (done)
  );
`else
  // Counter only exists when the count outputs are built.
  logic w_unused;
  assign w_unused = w_shift;
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed self-checking bench for parallel_to_serial
module tb_parallel_to_serial;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic        en;
  logic [31:0] data_in;
  logic        ser;
`ifdef P2S_BIT_COUNT_EN
  logic [5:0]  bit_cnt;
  logic        done;
`endif

  int          n_tests;
  int          n_fail;
  logic [31:0] r_word;
  logic        r_any;

  parallel_to_serial #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .en      (en),
    .data_in (data_in),
`ifdef P2S_BIT_COUNT_EN
    .bit_cnt (bit_cnt),
    .done    (done),
`endif
    .ser     (ser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 2 time units past it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Sample ser mid-cycle (as a receiver would before the edge), then clock.
  task automatic read_bits(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      #1;
      r_word[31-(start+i)] = ser;
      tick();
    end
  endtask

  // Clock n edges and OR together ser sampled in every cycle.
  task automatic idle_edges(input int n);
    r_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      r_any = r_any | ser;
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r_word  = '0;
    reset_n = 1'b0;
    load    = 1'b0;
    en      = 1'b0;
    data_in = '0;

    // Reset state
    #3;
    check("reset_ser", {31'd0, ser}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("reset_cnt", {26'd0, bit_cnt}, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    // Basic readout
    data_in = 32'hA5A5_0F0F;
    load    = 1'b1;
    tick(); tick(); tick();
    load    = 1'b0;
    data_in = 32'h0;
    en      = 1'b1;
    #1;
    check("basic_msb_before_edge", {31'd0, ser}, 32'd1);
`ifdef P2S_BIT_COUNT_EN
    check("basic_cnt_after_load", {26'd0, bit_cnt}, 32'd0);
`endif
    r_word = '0;
    read_bits(32, 0);
    check("basic_word", r_word, 32'hA5A5_0F0F);

    // Overrun
    idle_edges(8);
    check("overrun_ser", {31'd0, r_any}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("overrun_cnt", {26'd0, bit_cnt}, 32'd32);
    check("overrun_done", {31'd0, done}, 32'd1);
`endif

    // Enable gating
    en      = 1'b0;
    data_in = 32'hFFFF_FFFF;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    idle_edges(5);
    check("gate_ser_low", {31'd0, r_any}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("gate_cnt", {26'd0, bit_cnt}, 32'd0);
    check("gate_done", {31'd0, done}, 32'd0);
`endif
    en = 1'b1;
    r_word = '0;
    read_bits(32, 0);
    check("gate_word", r_word, 32'hFFFF_FFFF);

    // Pause mid-stream
    en      = 1'b0;
    data_in = 32'h1234_5678;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    en      = 1'b1;
    r_word  = '0;
    read_bits(10, 0);
    en = 1'b0;
    idle_edges(4);
    check("pause_ser_low", {31'd0, r_any}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("pause_cnt", {26'd0, bit_cnt}, 32'd10);
`endif
    en = 1'b1;
    read_bits(22, 10);
    check("pause_word", r_word, 32'h1234_5678);

    // Load priority over en
    load    = 1'b1;
    en      = 1'b1;
    data_in = 32'h8000_0000;
    tick();
    #1;
    check("prio_msb_1", {31'd0, ser}, 32'd1);
    data_in = 32'h0000_0001;
    tick();
    #1;
    check("prio_msb_0", {31'd0, ser}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("prio_cnt", {26'd0, bit_cnt}, 32'd0);
`endif
    load   = 1'b0;
    r_word = '0;
    tick();
    // Edge above was with load=0 and en=1, so bit 31 already went out (0).
    read_bits(31, 1);
    check("prio_word", r_word, 32'h0000_0001);

    // Reset mid-readout
    data_in = 32'hA5A5_0F0F;
    load    = 1'b1;
    tick();
    load = 1'b0;
    read_bits(5, 0);
    #1;
    check("midrst_before", {31'd0, ser}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_ser", {31'd0, ser}, 32'd0);
`ifdef P2S_BIT_COUNT_EN
    check("midrst_cnt", {26'd0, bit_cnt}, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    idle_edges(3);
    check("midrst_after_ser", {31'd0, r_any}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
